// File: rtl/naive_intt_seq_if.sv
// Handshake and data bundle for naive_intt_seq: input bundle, modulus parameters and result.
// The bit-reversed input option (INTT_BITREV_IN_EN) lives in the core, not here.
interface naive_intt_seq_if #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] data_in;
  logic [W-1:0]   omega_inv;
  logic [W-1:0]   n_inv;
  logic [W-1:0]   mod;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] data_out;
  logic           busy;
  logic           err;

  modport master (
    output in_valid, data_in, omega_inv, n_inv, mod, out_ready,
    input  in_ready, out_valid, data_out, busy, err
  );

  modport slave (
    input  in_valid, data_in, omega_inv, n_inv, mod, out_ready,
    output in_ready, out_valid, data_out, busy, err
  );
endinterface

// File: rtl/naive_intt_seq.sv
// Sequential naive inverse NTT using a single modular MAC over N*(N+1) cycles.
// Optional INTT_BITREV_IN_EN: input slot j carries X[bitrev(j)]; output is always natural order.
module naive_intt_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned N = 8
) (
  input logic              clk,
  input logic              rst,
  naive_intt_seq_if.slave  bus
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StMac, StScale, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  winv_q, winv_d;
  logic [W-1:0]  ninv_q, ninv_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  tw_q, tw_d;
  logic [W-1:0]  step_q, step_d;
  logic [CW-1:0] i_q, i_d;
  logic [CW-1:0] j_q, j_d;
  logic          err_q, err_d;
  logic [W-1:0]  x_q [N];
  logic [W-1:0]  x_d [N];
  logic [W-1:0]  res_q [N];
  logic [W-1:0]  res_d [N];

  logic [2*W-1:0] mac_prod, tw_prod, step_prod, scale_prod;
  logic [2*W:0]   mac_sum;

  // Full-width remainder; a modulus below 2 forces every stored value to zero.
  function automatic logic [W-1:0] red(input logic [2*W:0] v, input logic [W-1:0] m);
    if (m < W'(2)) return '0;
    return W'(v % (2*W+1)'(m));
  endfunction

  function automatic logic [CW-1:0] load_idx(input logic [CW-1:0] slot);
`ifdef INTT_BITREV_IN_EN
    logic [CW-1:0] r;
    for (int b = 0; b < int'(CW); b++) r[b] = slot[int'(CW) - 1 - b];
    return r;
`else
    return slot;
`endif
  endfunction

  always_comb begin
    mac_prod   = (2*W)'(x_q[j_q]) * (2*W)'(tw_q);
    mac_sum    = (2*W+1)'(acc_q) + (2*W+1)'(mac_prod);
    tw_prod    = (2*W)'(tw_q) * (2*W)'(step_q);
    step_prod  = (2*W)'(step_q) * (2*W)'(winv_q);
    scale_prod = (2*W)'(acc_q) * (2*W)'(ninv_q);
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    winv_d  = winv_q;
    ninv_d  = ninv_q;
    acc_d   = acc_q;
    tw_d    = tw_q;
    step_d  = step_q;
    i_d     = i_q;
    j_d     = j_q;
    err_d   = err_q;
    for (int k = 0; k < int'(N); k++) begin
      x_d[k]   = x_q[k];
      res_d[k] = res_q[k];
    end

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          q_d    = bus.mod;
          winv_d = red((2*W+1)'(bus.omega_inv), bus.mod);
          ninv_d = red((2*W+1)'(bus.n_inv), bus.mod);
          for (int k = 0; k < int'(N); k++) begin
            x_d[load_idx(CW'(k))] = red((2*W+1)'(bus.data_in[W*k +: W]), bus.mod);
          end
          acc_d   = '0;
          tw_d    = W'(bus.mod >= W'(2));
          step_d  = W'(bus.mod >= W'(2));
          i_d     = '0;
          j_d     = '0;
          err_d   = bus.mod < W'(2);
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = red(mac_sum, q_q);
        tw_d  = red((2*W+1)'(tw_prod), q_q);
        j_d   = j_q + CW'(1);
        if (j_q == CW'(N - 1)) state_d = StScale;
      end
      StScale: begin
        res_d[i_q] = red((2*W+1)'(scale_prod), q_q);
        acc_d      = '0;
        tw_d       = W'(q_q >= W'(2));
        step_d     = red((2*W+1)'(step_prod), q_q);
        j_d        = '0;
        if (i_q == CW'(N - 1)) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + CW'(1);
          state_d = StMac;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      q_q     <= '0;
      winv_q  <= '0;
      ninv_q  <= '0;
      acc_q   <= '0;
      tw_q    <= '0;
      step_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        x_q[k]   <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      winv_q  <= winv_d;
      ninv_q  <= ninv_d;
      acc_q   <= acc_d;
      tw_q    <= tw_d;
      step_q  <= step_d;
      i_q     <= i_d;
      j_q     <= j_d;
      err_q   <= err_d;
      for (int k = 0; k < int'(N); k++) begin
        x_q[k]   <= x_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(N); k++) bus.data_out[W*k +: W] = res_q[k];
    bus.in_ready  = (state_q == StIdle);
    bus.busy      = (state_q == StMac) || (state_q == StScale);
    bus.out_valid = (state_q == StDone);
    bus.err       = (state_q == StDone) && err_q;
  end

endmodule
